// File: rtl/rd53_afe_model_pkg.sv
// Shared defaults and the ToT duration helper for the RD53 AFE behavioural model.
// calc_tot applies the clamp-to-1 and saturation rules to an over-threshold charge.
package rd53_afe_model_pkg;

  localparam int DAC_W     = 12;
  localparam int TOT_W     = 8;
  localparam int SHIFT_LO  = 2;
  localparam int SHIFT_HI  = 3;
  localparam int TRIM_STEP = 4;
  localparam int TOT_MAX   = (1 << TOT_W) - 1;

  function automatic logic [31:0] calc_tot(
    input logic [31:0] q,
    input logic [31:0] thr,
    input logic [31:0] shift
  );
    logic [31:0] d;
    d = 32'd0;
    if (q > thr) begin
      d = (q - thr) >> shift;
      // Any over-threshold charge yields at least one cycle of HIT.
      if (d == 32'd0) begin
        d = 32'd1;
      end
      if (d > 32'(TOT_MAX)) begin
        d = 32'(TOT_MAX);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/rd53_afe_model_ch.sv
// One AFE channel: threshold/trim, gain-dependent discharge, pile-up counter,
// and the registered HIT/BUSY outputs.
module rd53_afe_model_ch
  import rd53_afe_model_pkg::calc_tot;
#(
  parameter int DAC_W     = rd53_afe_model_pkg::DAC_W,
  parameter int TOT_W     = rd53_afe_model_pkg::TOT_W,
  parameter int SHIFT_LO  = rd53_afe_model_pkg::SHIFT_LO,
  parameter int SHIFT_HI  = rd53_afe_model_pkg::SHIFT_HI,
  parameter int TRIM_STEP = rd53_afe_model_pkg::TRIM_STEP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rise,
  input  logic [DAC_W:0]   i_q,
  input  logic [DAC_W-1:0] i_vth,
  input  logic [3:0]       i_trim,
  input  logic             i_inj_en,
  input  logic             i_gain_sel,
  input  logic             i_power_down,
  input  logic             i_pixel_in,
  output logic             o_hit,
  output logic             o_busy
);

  localparam logic [31:0] TOT_MAX_L = 32'((1 << TOT_W) - 1);

  logic [TOT_W-1:0] r_cnt;
  logic [TOT_W-1:0] w_cnt_next;
  logic             r_hit;
  logic             r_busy;
  logic [31:0]      w_thr;
  logic [31:0]      w_shift;
  logic [31:0]      w_d_raw;
  logic [31:0]      w_d;
  logic [31:0]      w_dec;
  logic [31:0]      w_sum;

  // Threshold is computed wide so VTH plus trim never wraps.
  assign w_thr   = 32'(i_vth) + 32'(i_trim) * 32'(TRIM_STEP);
  assign w_shift = i_gain_sel ? 32'(SHIFT_HI) : 32'(SHIFT_LO);
  assign w_d_raw = calc_tot(32'(i_q), w_thr, w_shift);
  assign w_d     = (w_d_raw > TOT_MAX_L) ? TOT_MAX_L : w_d_raw;
  assign w_dec   = (r_cnt == '0) ? 32'd0 : (32'(r_cnt) - 32'd1);
  assign w_sum   = w_dec + w_d;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_power_down) begin
      w_cnt_next = '0;
    end else if (i_rise && i_inj_en && (w_d != 32'd0)) begin
      // Pile-up: new charge adds on top of the already-decremented count.
      w_cnt_next = (w_sum > TOT_MAX_L) ? '1 : w_sum[TOT_W-1:0];
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - TOT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_hit  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_hit  <= i_power_down | i_pixel_in | (w_cnt_next != '0);
      r_busy <= (w_cnt_next != '0);
    end
  end

  assign o_hit  = r_hit;
  assign o_busy = r_busy;

endmodule

// File: rtl/rd53_afe_model_mc.sv
// Multi-channel RD53 AFE model: shared strobe edge detection and injected-charge
// computation feeding NCH independent channels.
module rd53_afe_model_mc #(
  parameter int NCH       = 8,
  parameter int DAC_W     = rd53_afe_model_pkg::DAC_W,
  parameter int TOT_W     = rd53_afe_model_pkg::TOT_W,
  parameter int SHIFT_LO  = rd53_afe_model_pkg::SHIFT_LO,
  parameter int SHIFT_HI  = rd53_afe_model_pkg::SHIFT_HI,
  parameter int TRIM_STEP = rd53_afe_model_pkg::TRIM_STEP
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               S0,
  input  logic               S1,
  input  logic [DAC_W-1:0]   CAL_HI,
  input  logic [DAC_W-1:0]   CAL_MI,
  input  logic [DAC_W-1:0]   VTH,
  input  logic [NCH-1:0]     INJ_EN,
  input  logic [NCH-1:0]     GAIN_SEL,
  input  logic [NCH-1:0]     POWER_DOWN,
  input  logic [4*NCH-1:0]   TH_DAC,
  input  logic [NCH-1:0]     PIXEL_IN,
  output logic [NCH-1:0]     HIT,
  output logic [NCH-1:0]     BUSY
);

  logic             r_s0_q;
  logic             r_s1_q;
  logic             w_rise0;
  logic             w_rise1;
  logic             w_rise;
  logic [DAC_W-1:0] w_diff;
  logic [DAC_W:0]   w_q0;
  logic [DAC_W:0]   w_q1;
  logic [DAC_W:0]   w_q;

  // Edge registers come out of reset high so a strobe held across release is ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s0_q <= 1'b1;
      r_s1_q <= 1'b1;
    end else begin
      r_s0_q <= S0;
      r_s1_q <= S1;
    end
  end

  assign w_rise0 = S0 & ~r_s0_q;
  assign w_rise1 = S1 & ~r_s1_q;
  assign w_rise  = w_rise0 | w_rise1;

  assign w_diff = (CAL_HI >= CAL_MI) ? (CAL_HI - CAL_MI) : '0;
  assign w_q0   = w_rise0 ? {1'b0, w_diff} : '0;
  assign w_q1   = w_rise1 ? {1'b0, CAL_MI} : '0;
  assign w_q    = w_q0 + w_q1;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      rd53_afe_model_ch #(
        .DAC_W     (DAC_W),
        .TOT_W     (TOT_W),
        .SHIFT_LO  (SHIFT_LO),
        .SHIFT_HI  (SHIFT_HI),
        .TRIM_STEP (TRIM_STEP)
      ) u_ch (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_rise       (w_rise),
        .i_q          (w_q),
        .i_vth        (VTH),
        .i_trim       (TH_DAC[4*gi +: 4]),
        .i_inj_en     (INJ_EN[gi]),
        .i_gain_sel   (GAIN_SEL[gi]),
        .i_power_down (POWER_DOWN[gi]),
        .i_pixel_in   (PIXEL_IN[gi]),
        .o_hit        (HIT[gi]),
        .o_busy       (BUSY[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rd53_afe_model_mc.sv
// Directed bench for rd53_afe_model_mc: expected pulse lengths are queued when
// stimulus is applied and popped when the measured HIT pulse completes.
module tb_rd53_afe_model_mc;

  localparam int NCH = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             S0, S1;
  logic [11:0]      CAL_HI, CAL_MI, VTH;
  logic [NCH-1:0]   INJ_EN, GAIN_SEL, POWER_DOWN, PIXEL_IN;
  logic [4*NCH-1:0] TH_DAC;
  logic [NCH-1:0]   HIT, BUSY;

  always #5 CLK = ~CLK;

  rd53_afe_model_mc #(.NCH(NCH)) dut (
    .CLK(CLK), .RESET(RESET), .S0(S0), .S1(S1),
    .CAL_HI(CAL_HI), .CAL_MI(CAL_MI), .VTH(VTH),
    .INJ_EN(INJ_EN), .GAIN_SEL(GAIN_SEL), .POWER_DOWN(POWER_DOWN),
    .TH_DAC(TH_DAC), .PIXEL_IN(PIXEL_IN), .HIT(HIT), .BUSY(BUSY)
  );

  typedef struct {
    string tag;
    int    len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input int len);
    exp_t e;
    e.tag = tag;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Counts HIT/BUSY high cycles on one channel; lat is the negedge index of the first HIT.
  task automatic measure(input int ch, input int maxc,
                         output int hlen, output int blen, output int lat);
    hlen = 0;
    blen = 0;
    lat  = -1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge CLK);
      if (HIT[ch]) begin
        if (lat < 0) lat = c + 1;
        hlen++;
      end
      if (BUSY[ch]) blen++;
      if (lat >= 0 && !HIT[ch] && !BUSY[ch]) break;
    end
  endtask

  task automatic check_pop(input int hlen, input int blen, input int lat);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_empty observed=none expected=entry");
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, "_hit_len"}, hlen, e.len);
    chk({e.tag, "_busy_len"}, blen, e.len);
    // Strobe set just after a posedge: one negedge precedes the sampling edge.
    if (e.len > 0) chk({e.tag, "_latency"}, lat, 2);
    $display("txn %s: hit_len=%0d busy_len=%0d lat=%0d", e.tag, hlen, blen, lat);
  endtask

  task automatic expect_pulse(input int ch, input int maxc);
    int h, b, l;
    measure(ch, maxc, h, b, l);
    check_pop(h, b, l);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input logic [11:0] hi, input logic [11:0] mi,
                         input logic [11:0] vth, input logic [3:0] trim);
    CAL_HI = hi;
    CAL_MI = mi;
    VTH    = vth;
    TH_DAC = {NCH{trim}};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, b0, l0, h1, b1, l1, h2, b2, l2, rem, rehit, pile, total;

    RESET = 1'b1; S0 = 1'b0; S1 = 1'b0;
    INJ_EN = '1; GAIN_SEL = '0; POWER_DOWN = '0; PIXEL_IN = '0;
    set_cfg(12'd500, 12'd50, 12'd100, 4'd0);
    idle(3);
    @(negedge CLK);
    chk("reset_hit", int'(HIT), 0);
    chk("reset_busy", int'(BUSY), 0);
    @(posedge CLK); #1 RESET = 1'b0;
    idle(2);

    // Basic injection: Q=450, thr=100 -> 350>>2 = 87
    S0 = 1'b1; push("basic", 87); expect_pulse(0, 300); S0 = 1'b0; idle(2);

    GAIN_SEL = '1;
    S0 = 1'b1; push("gain_hi", 43); expect_pulse(0, 300); S0 = 1'b0; idle(2);
    GAIN_SEL = '0;

    // Trim 15 -> thr=160 -> 290>>2 = 72
    set_cfg(12'd500, 12'd50, 12'd100, 4'd15);
    S0 = 1'b1; push("trim15", 72); expect_pulse(0, 300); S0 = 1'b0; idle(2);

    set_cfg(12'd500, 12'd50, 12'd100, 4'd0);
    S1 = 1'b1; push("sub_thr", 0); expect_pulse(0, 20); S1 = 1'b0; idle(2);

    // Q=103 vs thr=100: 3>>2 = 0, clamped to 1
    set_cfg(12'd153, 12'd50, 12'd100, 4'd0);
    S0 = 1'b1; push("min_one", 1); expect_pulse(0, 20); S0 = 1'b0; idle(2);

    set_cfg(12'd4095, 12'd0, 12'd0, 4'd0);
    S0 = 1'b1; push("saturate", 255); expect_pulse(0, 400); S0 = 1'b0; idle(2);

    // Simultaneous strobes: Q = 450 + 50 = 500 -> 400>>2 = 100
    set_cfg(12'd500, 12'd50, 12'd100, 4'd0);
    S0 = 1'b1; S1 = 1'b1; push("both", 100); expect_pulse(0, 300);
    S0 = 1'b0; S1 = 1'b0; idle(2);

    S0 = 1'b1; push("held", 87); expect_pulse(0, 300);
    rehit = 0;
    for (int c = 0; c < 211; c++) begin
      @(negedge CLK);
      if (HIT[0]) rehit++;
    end
    chk("held_rehit", rehit, 0);
    S0 = 1'b0; idle(2);

    @(posedge CLK); #1 RESET = 1'b1; S0 = 1'b1;
    idle(3);
    RESET = 1'b0;
    push("held_over_reset", 0); expect_pulse(0, 20);
    S0 = 1'b0; idle(2);

    // Pile-up: second rise sampled 21 edges after the first; cnt 67 -> 66 + 87
    pile = (87 - 20) - 1 + 87;
    if (pile > 255) pile = 255;
    total = 21 + pile;
    push("pileup", total);
    S0 = 1'b1;
    rem = 0;
    fork
      measure(0, 600, h0, b0, l0);
      begin
        @(posedge CLK); #1 S0 = 1'b0;
        repeat (20) @(posedge CLK);
        #1 S0 = 1'b1;
        @(posedge CLK);
        for (int c = 0; c < 400; c++) begin
          @(negedge CLK);
          if (HIT[0]) rem++;
          else break;
        end
      end
    join
    check_pop(h0, b0, l0);
    chk("pileup_cnt_after_edge", rem, pile);
    S0 = 1'b0; idle(2);

    // Per-channel independence: ch0 masked, ch1 default, ch2 high gain
    INJ_EN = 8'hFE; GAIN_SEL = 8'h04;
    push("inj_off_ch0", 0); push("ch1", 87); push("ch2_gain", 43);
    S0 = 1'b1;
    fork
      measure(0, 120, h0, b0, l0);
      measure(1, 300, h1, b1, l1);
      measure(2, 300, h2, b2, l2);
    join
    check_pop(h0, b0, l0); check_pop(h1, b1, l1); check_pop(h2, b2, l2);
    S0 = 1'b0; INJ_EN = '1; GAIN_SEL = '0; idle(2);

    // Power-down mid-pulse forces HIT high with the counter cleared
    S0 = 1'b1; idle(10); S0 = 1'b0;
    POWER_DOWN[0] = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("pd_hit", int'(HIT[0]), 1);
    chk("pd_busy", int'(BUSY[0]), 0);
    chk("pd_other_ch_busy", int'(BUSY[1]), 1);
    idle(4);
    POWER_DOWN[0] = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("pd_release_hit", int'(HIT[0]), 0);
    $display("txn power_down: hit0=%0b busy1=%0b", HIT[0], BUSY[1]);
    idle(100);

    push("pixel_in", 5);
    PIXEL_IN[0] = 1'b1;
    fork
      measure(0, 30, h0, b0, l0);
      begin idle(5); PIXEL_IN[0] = 1'b0; end
    join
    chk("pixel_in_hit_len", h0, 5);
    chk("pixel_in_latency", l0, 2);
    chk("pixel_in_busy", b0, 0);
    void'(exp_q.pop_front());
    $display("txn pixel_in: hit_len=%0d lat=%0d", h0, l0);
    idle(2);

    // Reset mid-pulse
    S0 = 1'b1; idle(10); S0 = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("reset_mid_hit", int'(HIT), 0);
    chk("reset_mid_busy", int'(BUSY), 0);
    $display("txn reset_mid: hit=%0h busy=%0h", HIT, BUSY);
    RESET = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
